// File: rtl/oam_dma.sv
// Sprite DMA engine: on a CPU write to TRIG_ADDR, stalls the CPU and copies
// NUM_BYTES bytes from page {data,00} into OAM_DATA_ADDR with NES cycle timing.
module oam_dma #(
  parameter logic [15:0] TRIG_ADDR     = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned NUM_BYTES     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_rw_i,
  input  logic [7:0]  cpu_data_i,
  input  logic [7:0]  bus_data_i,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] bus_addr_o,
  output logic        bus_rw_o,
  output logic [7:0]  bus_data_o,
  output logic        done
);

  localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             parity_q;
  logic [7:0]       page_q, page_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             rdy_q, rdy_d;
  logic             active_q, active_d;
  logic [15:0]      addr_q, addr_d;
  logic             rw_q, rw_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             done_q, done_d;

  logic             trigger;
  logic             busy_d;

  assign trigger = (cpu_addr_i == TRIG_ADDR) && !cpu_rw_i;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          page_d  = cpu_data_i;
          idx_d   = '0;
          state_d = S_HALT;
        end
      end
      S_HALT:  state_d = parity_q ? S_ALIGN : S_READ;
      S_ALIGN: state_d = S_READ;
      S_READ:  state_d = S_WRITE;
      S_WRITE: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers are loaded from the next state so that, once the edge
  // passes, they reflect the state held in that same cycle.
  always_comb begin
    busy_d   = (state_d == S_HALT) || (state_d == S_ALIGN) ||
               (state_d == S_READ) || (state_d == S_WRITE);
    rdy_d    = !busy_d;
    active_d = busy_d;
    rw_d     = (state_d != S_WRITE);
    done_d   = (state_d == S_DONE);
    wdata_d  = wdata_q;
    addr_d   = '0;
    unique case (state_d)
      S_HALT, S_ALIGN: addr_d = TRIG_ADDR;
      S_READ:          addr_d = {page_d, 8'(idx_d)};
      S_WRITE:         addr_d = OAM_DATA_ADDR;
      default:         addr_d = '0;
    endcase
    if (state_q == S_READ) begin
      wdata_d = bus_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      page_q   <= '0;
      idx_q    <= '0;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b1;
      wdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      page_q   <= page_d;
      idx_q    <= idx_d;
      rdy_q    <= rdy_d;
      active_q <= active_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
    end
  end

  assign rdy        = rdy_q;
  assign dma_active = active_q;
  assign bus_addr_o = addr_q;
  assign bus_rw_o   = rw_q;
  assign bus_data_o = wdata_q;
  assign done       = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Randomized self-checking bench for oam_dma against a transaction-level
// model: expected reads, writes and stall length derived from page and parity.
module tb_oam_dma;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] OAM  = 16'h2004;
  localparam int          NB   = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr_i;
  logic        cpu_rw_i;
  logic [7:0]  cpu_data_i;
  logic [7:0]  bus_data_i;
  logic        rdy, dma_active, bus_rw_o, done;
  logic [15:0] bus_addr_o;
  logic [7:0]  bus_data_o;

  logic [7:0]  mem [0:65535];

  oam_dma #(.TRIG_ADDR(TRIG), .OAM_DATA_ADDR(OAM), .NUM_BYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr_i(cpu_addr_i), .cpu_rw_i(cpu_rw_i), .cpu_data_i(cpu_data_i),
    .bus_data_i(bus_data_i),
    .rdy(rdy), .dma_active(dma_active),
    .bus_addr_o(bus_addr_o), .bus_rw_o(bus_rw_o), .bus_data_o(bus_data_o),
    .done(done)
  );

  always #5 clk = ~clk;
  assign bus_data_i = mem[bus_addr_o];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Edges seen out of reset; the parity flop equals edges%2 in each cycle.
  int unsigned edges = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  bit              rec = 0;
  int              stall_n, done_n, halt_n, bad_wr;
  logic [15:0]     rd_q[$];
  logic [7:0]      wr_q[$];

  always @(negedge clk) begin
    if (rec) begin
      if (!rdy) stall_n++;
      if (done) done_n++;
      if (dma_active && bus_addr_o == TRIG) halt_n++;
      else if (dma_active && bus_rw_o) rd_q.push_back(bus_addr_o);
      if (!bus_rw_o) begin
        if (bus_addr_o != OAM || !dma_active) bad_wr++;
        wr_q.push_back(bus_data_o);
      end
    end
  end

  task automatic idle_bus();
    cpu_addr_i = 16'h0000;
    cpu_rw_i   = 1'b1;
    cpu_data_i = 8'h00;
  endtask

  task automatic start_dma(input logic [7:0] page, input int want_align, output int align);
    if (want_align >= 0 && int'((edges + 1) % 2) != want_align) @(negedge clk);
    align = int'((edges + 1) % 2);
    stall_n = 0; done_n = 0; halt_n = 0; bad_wr = 0;
    rd_q.delete(); wr_q.delete();
    rec = 1;
    cpu_addr_i = TRIG; cpu_rw_i = 1'b0; cpu_data_i = page;
    @(negedge clk);
    idle_bus();
  endtask

  // Runs one transfer (caller sits on a negedge) and checks it against the model.
  task automatic run_dma(input logic [7:0] page, input int want_align,
                         input int retrig_at, input bit trig_on_done);
    int align;
    bit seen;
    seen = 0;
    start_dma(page, want_align, align);
    for (int i = 0; i < 700 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (i == retrig_at) begin
          cpu_addr_i = TRIG; cpu_rw_i = 1'b0; cpu_data_i = page ^ 8'h01;
        end else idle_bus();
        @(negedge clk);
      end
    end
    check("done_seen", seen, 1);
    if (trig_on_done) begin
      cpu_addr_i = TRIG; cpu_rw_i = 1'b0; cpu_data_i = 8'h05;
    end
    @(negedge clk);
    idle_bus();
    rec = 0;
    check("stall_len", stall_n, 513 + align);
    check("done_pulses", done_n, 1);
    check("halt_align_cycles", halt_n, 1 + align);
    check("bad_writes", bad_wr, 0);
    check("rdy_after", rdy, 1);
    check("active_after", dma_active, 0);
    check("n_reads", rd_q.size(), NB);
    check("n_writes", wr_q.size(), NB);
    for (int i = 0; i < NB && i < rd_q.size(); i++)
      check("rd_addr", rd_q[i], {page, 8'(i)});
    for (int i = 0; i < NB && i < wr_q.size(); i++)
      check("wr_data", wr_q[i], mem[{page, 8'(i)}]);
    if (trig_on_done) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("done_trig_ignored", dma_active, 0);
      end
    end
  endtask

  task automatic fill_page(input logic [7:0] page, input bit pattern);
    for (int i = 0; i < 256; i++)
      mem[{page, 8'(i)}] = pattern ? (8'(i) ^ 8'hA5) : 8'($urandom);
  endtask

  initial begin
    int align;
    bit hit;
    logic [7:0] pg;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    fill_page(8'h02, 1);
    idle_bus();
    rst = 1'b1;
    #12;
    check("rst_rdy", rdy, 1);
    check("rst_active", dma_active, 0);
    check("rst_addr", bus_addr_o, 0);
    check("rst_rw", bus_rw_o, 1);
    check("rst_wdata", bus_data_o, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    run_dma(8'h02, 0, -1, 0);   // even start
    run_dma(8'h02, 1, -1, 0);   // odd start
    run_dma(8'h02, -1, 137, 0); // ignored mid-transfer retrigger
    run_dma(8'h02, -1, -1, 1);  // trigger during DONE ignored
    fill_page(8'hFF, 0);
    run_dma(8'hFF, -1, -1, 0);  // last page
    run_dma(8'h02, -1, -1, 0);  // back-to-back from first idle cycle

    // CPU read of the trigger address must not start a transfer.
    cpu_addr_i = TRIG; cpu_rw_i = 1'b1; cpu_data_i = 8'h02;
    @(negedge clk);
    idle_bus();
    for (int k = 0; k < 3; k++) begin
      check("read_no_dma_active", dma_active, 0);
      check("read_no_dma_rdy", rdy, 1);
      @(negedge clk);
    end

    // Reset partway through a transfer.
    start_dma(8'h02, -1, align);
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (wr_q.size() >= 100) hit = 1;
      else @(negedge clk);
    end
    check("reach_byte100", hit, 1);
    rec = 0;
    #2 rst = 1'b1;
    #1;
    check("midrst_rdy", rdy, 1);
    check("midrst_active", dma_active, 0);
    check("midrst_rw", bus_rw_o, 1);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_dma(8'h02, 1, -1, 0);

    for (int r = 0; r < 4; r++) begin
      pg = 8'($urandom_range(0, 255));
      if (pg == 8'h40) pg = 8'h41;
      fill_page(pg, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_dma(pg, -1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 500)) : -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
